fifo_sync_ctrl: RTL and testbench

//  Synchronous single-clock FIFO. Its active-low read/write strobes and over_flow/under_flow status

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_sync_ctrl_if.sv | 29 ++
 rtl/fifo_dpram.sv | 34 +++
 rtl/fifo_sync_ctrl.sv | 84 ++++++++
 tb/tb_fifo_sync_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and types for the synchronous FIFO
package fifo_pkg;
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
  typedef logic [FIFO_AW:0] count_t;
endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// rtl/fifo_sync_ctrl_if.sv - strobe, data and status bundle of the synchronous FIFO
interface fifo_sync_ctrl_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             write_n;
  logic             read_n;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [AW:0]      count;
  logic             over_flow;
  logic             under_flow;
  logic             wr_err;
  logic             rd_err;

  modport master (
    output write_n, read_n, data_in,
    input  data_out, count, over_flow, under_flow, wr_err, rd_err
  );

  modport slave (
    input  write_n, read_n, data_in,
    output data_out, count, over_flow, under_flow, wr_err, rd_err
  );
endinterface

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - DEPTH x WIDTH register array, one write port, one registered read port
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads sample the pre-edge contents, so a same-address write cannot bypass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO with active-low strobes, occupancy and sticky errors
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  fifo_sync_ctrl_if.slave  bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          wr_req;
  logic          rd_req;
  logic          wr_ok;
  logic          rd_ok;
  logic          over_q;
  logic          under_q;
  logic          wr_err_q;
  logic          rd_err_q;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    wr_req    = !bus.write_n;
    rd_req    = !bus.read_n;
    rd_ok     = rd_req && (count_q != '0);
    wr_ok     = wr_req && ((count_q != FULL) || rd_ok);
    count_nxt = count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
      over_q  <= (count_nxt == FULL);
      under_q <= (count_nxt == '0);
      if (wr_req && !wr_ok) begin
        wr_err_q <= 1'b1;
      end
      if (rd_req && !rd_ok) begin
        rd_err_q <= 1'b1;
      end
    end
  end

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  assign bus.count      = count_q;
  assign bus.over_flow  = over_q;
  assign bus.under_flow = under_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.rd_err     = rd_err_q;
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - vector table, corner sequences and randomized model check of fifo_sync_ctrl
module tb_fifo_sync_ctrl;
  import fifo_pkg::*;

  localparam int W = FIFO_WIDTH;
  localparam int D = FIFO_DEPTH;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fifo_sync_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_sync_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic         wn;
    logic         rn;
    logic [W-1:0] din;
    int           cnt;
    logic [W-1:0] dout;
    logic         ov;
    logic         un;
    logic         we;
    logic         re;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered queue of buffered words plus the visible registers.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_werr, m_rerr, m_over, m_under;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_werr  = 1'b0;
    m_rerr  = 1'b0;
    m_over  = 1'b0;
    m_under = 1'b0;
  endtask

  task automatic tick(input logic wn, input logic rn, input logic [W-1:0] din);
    bit rd, wr;
    bus.write_n = wn;
    bus.read_n  = rn;
    bus.data_in = din;
    @(posedge clock);
    #1;
    rd = !rn && (q.size() != 0);
    wr = !wn && ((q.size() < D) || rd);
    if (!rn && !rd) m_rerr = 1'b1;
    if (!wn && !wr) m_werr = 1'b1;
    if (rd) m_dout = q.pop_front();
    if (wr) q.push_back(din);
    m_over  = (q.size() == D);
    m_under = (q.size() == 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"},      32'(bus.count),      32'(q.size()));
    chk({tag, " data_out"},   32'(bus.data_out),   32'(m_dout));
    chk({tag, " over_flow"},  32'(bus.over_flow),  32'(m_over));
    chk({tag, " under_flow"}, 32'(bus.under_flow), 32'(m_under));
    chk({tag, " wr_err"},     32'(bus.wr_err),     32'(m_werr));
    chk({tag, " rd_err"},     32'(bus.rd_err),     32'(m_rerr));
  endtask

  task automatic do_reset();
    bus.write_n = 1'b1;
    bus.read_n  = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vec_t v;

    // Table: fill, overfill, drain, over-read, then simultaneous strobes on empty.
    for (int i = 0; i < D; i++) begin
      v = '{1'b0, 1'b1, W'(i + 1), i + 1, '0, (i == D - 1), 1'b0, 1'b0, 1'b0};
      tbl.push_back(v);
    end
    v = '{1'b0, 1'b1, 8'h77, D, '0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl.push_back(v);
    for (int i = 0; i < D; i++) begin
      v = '{1'b1, 1'b0, 8'h00, D - 1 - i, W'(i + 1), 1'b0, (i == D - 1), 1'b1, 1'b0};
      tbl.push_back(v);
    end
    v = '{1'b1, 1'b0, 8'h00, 0, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl.push_back(v);
    v = '{1'b0, 1'b0, 8'hA5, 1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl.push_back(v);
    v = '{1'b1, 1'b0, 8'h00, 0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl.push_back(v);

    bus.write_n = 1'b1;
    bus.read_n  = 1'b1;
    bus.data_in = '0;
    reset       = 1'b1;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    chk("por count",      32'(bus.count),      0);
    chk("por under_flow", 32'(bus.under_flow), 0);
    chk("por over_flow",  32'(bus.over_flow),  0);
    chk("por data_out",   32'(bus.data_out),   0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, W'(8'hC0 + i));
    check_model("pre-reset traffic");

    // Reset asserted mid-traffic, held for three clocks while strobes stay active.
    bus.write_n = 1'b0;
    bus.read_n  = 1'b0;
    reset = 1'b1;
    #1;
    chk("async reset count", 32'(bus.count), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("in reset count",      32'(bus.count),      0);
      chk("in reset over_flow",  32'(bus.over_flow),  0);
      chk("in reset under_flow", 32'(bus.under_flow), 0);
      chk("in reset wr_err",     32'(bus.wr_err),     0);
    end
    bus.write_n = 1'b1;
    bus.read_n  = 1'b1;
    reset = 1'b0;
    model_reset();
    tick(1'b1, 1'b1, '0);
    chk("release under_flow", 32'(bus.under_flow), 1);
    check_model("after release");

    foreach (tbl[i]) begin
      tick(tbl[i].wn, tbl[i].rn, tbl[i].din);
      chk($sformatf("vec%0d count", i),      32'(bus.count),      32'(tbl[i].cnt));
      chk($sformatf("vec%0d data_out", i),   32'(bus.data_out),   32'(tbl[i].dout));
      chk($sformatf("vec%0d over_flow", i),  32'(bus.over_flow),  32'(tbl[i].ov));
      chk($sformatf("vec%0d under_flow", i), 32'(bus.under_flow), 32'(tbl[i].un));
      chk($sformatf("vec%0d wr_err", i),     32'(bus.wr_err),     32'(tbl[i].we));
      chk($sformatf("vec%0d rd_err", i),     32'(bus.rd_err),     32'(tbl[i].re));
    end

    // Full with both strobes: pass-through without loss, overflow or error.
    do_reset();
    for (int i = 0; i < D; i++) tick(1'b0, 1'b1, W'($urandom));
    check_model("full");
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, W'($urandom));
      chk("full both count",     32'(bus.count),     D);
      chk("full both over_flow", 32'(bus.over_flow), 1);
      chk("full both wr_err",    32'(bus.wr_err),    0);
      check_model("full both");
    end
    for (int i = 0; i < D; i++) begin
      tick(1'b1, 1'b0, '0);
      check_model("drain after full");
    end

    // Randomized traffic with phases biased toward filling and draining.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit fill;
      fill = ((i / 25) % 2) == 0;
      tick(($urandom_range(0, 99) < (fill ? 80 : 30)) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < (fill ? 30 : 80)) ? 1'b0 : 1'b1,
           W'($urandom));
      check_model("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
